// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts a Q5.27 Cartesian vector into
// atan2(y, x) and the CORDIC-gain-scaled magnitude, one micro-rotation per clock.
module cordic_vectoring #(
    parameter int WIDTH = 32,
    parameter int ITER  = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] magnitude,
    output logic [WIDTH-1:0] angle
);

    localparam logic signed [WIDTH-1:0] PI     = WIDTH'(32'h1921_FB54);
    localparam logic signed [WIDTH-1:0] NEG_PI = WIDTH'(32'hE6DE_04AC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic signed [WIDTH-1:0] x_sh, y_sh, x_nxt, y_nxt, z_nxt, atan_val;
    logic [4:0]              iter_q;
    logic                    zero_flag_q;
    logic                    accept, last_iter;

    // atan(2^-i) in Q5.27; beyond i=8 the value is 2^-i to within rounding
    function automatic logic [31:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    return 32'h0648_7ED5;
            5'd1:    return 32'h03B5_8CE1;
            5'd2:    return 32'h01F5_B760;
            5'd3:    return 32'h00FE_ADD5;
            5'd4:    return 32'h007F_D56F;
            5'd5:    return 32'h003F_FAAB;
            5'd6:    return 32'h001F_FF55;
            5'd7:    return 32'h000F_FFEB;
            5'd8:    return 32'h0007_FFFD;
            default: return 32'h0004_0000 >> (idx - 5'd9);
        endcase
    endfunction

    // Micro-rotation: drive y toward zero, accumulating the rotated angle in z
    always_comb begin
        x_sh     = x_q >>> iter_q;
        y_sh     = y_q >>> iter_q;
        atan_val = WIDTH'(atan_rom(iter_q));
        if (!y_q[WIDTH-1]) begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + atan_val;
        end else begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_val;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (iter_q == 5'(ITER - 1)) begin
                    last_iter = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= '0;
            zero_flag_q <= 1'b0;
            done        <= 1'b0;
            magnitude   <= '0;
            angle       <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                iter_q      <= '0;
                zero_flag_q <= (x_in == '0) && (y_in == '0);
                // Left half-plane: rotate by pi so iterations start with x >= 0
                if (!x_in[WIDTH-1]) begin
                    x_q <= x_in;
                    y_q <= y_in;
                    z_q <= '0;
                end else begin
                    x_q <= -x_in;
                    y_q <= -y_in;
                    z_q <= y_in[WIDTH-1] ? NEG_PI : PI;
                end
            end else if (state_q == RUN) begin
                x_q    <= x_nxt;
                y_q    <= y_nxt;
                z_q    <= z_nxt;
                iter_q <= iter_q + 5'd1;
                if (last_iter) begin
                    done      <= 1'b1;
                    magnitude <= zero_flag_q ? '0 : x_nxt;
                    angle     <= zero_flag_q ? '0 : z_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: directed quadrant/boundary cases, reset abort,
// continuous-start spacing and a random sweep against a real-valued atan2/hypot model.
module tb_cordic_vectoring;

    localparam int  W     = 32;
    localparam int  ITER  = 28;
    localparam int  TOL_A = 64;
    localparam int  TOL_M = 256;
    localparam real KGAIN = 1.6467602581210656;
    localparam real SCALE = 134217728.0;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x_in, y_in;
    logic         busy, done;
    logic [W-1:0] magnitude, angle;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_mag_q[$];
    logic [W-1:0] exp_ang_q[$];
    int           tol_mag_q[$];
    int           tol_ang_q[$];

    cordic_vectoring #(.WIDTH(W), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .magnitude (magnitude),
        .angle     (angle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp, input int tol);
        longint diff;
        checks++;
        diff = longint'(signed'(obs)) - longint'(signed'(exp));
        if (diff < 0) diff = -diff;
        if (diff > longint'(tol)) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic logic [W-1:0] to_q(input real r);
        longint v;
        v = longint'(r * SCALE);
        return v[W-1:0];
    endfunction

    function automatic real from_q(input logic [W-1:0] q);
        return real'(longint'(signed'(q))) / SCALE;
    endfunction

    task automatic push_exp(input logic [W-1:0] m, input logic [W-1:0] a,
                            input int tm, input int ta);
        exp_mag_q.push_back(m);
        exp_ang_q.push_back(a);
        tol_mag_q.push_back(tm);
        tol_ang_q.push_back(ta);
    endtask

    // Reference: polar conversion computed directly in real arithmetic
    task automatic push_model(input logic [W-1:0] xv, input logic [W-1:0] yv);
        real xr, yr;
        xr = from_q(xv);
        yr = from_q(yv);
        if (xv == '0 && yv == '0) push_exp('0, '0, 0, 0);
        else push_exp(to_q(KGAIN * $sqrt(xr * xr + yr * yr)), to_q($atan2(yr, xr)), TOL_M, TOL_A);
    endtask

    task automatic check_results(input string tag);
        if (exp_mag_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: done with no expected result queued", tag);
        end else begin
            check_val({tag, " mag"}, magnitude, exp_mag_q.pop_front(), tol_mag_q.pop_front());
            check_val({tag, " ang"}, angle, exp_ang_q.pop_front(), tol_ang_q.pop_front());
        end
    endtask

    // One isolated conversion; expectation must already be queued by the caller
    task automatic convert(input logic [W-1:0] xv, input logic [W-1:0] yv, input string tag);
        int   lat;
        logic busy_ok;
        x_in  = xv;
        y_in  = yv;
        start = 1'b1;
        tick();
        start = 1'b0;
        x_in  = $urandom;
        y_in  = $urandom;
        busy_ok = 1'b1;
        lat     = 0;
        while (!done && lat < ITER + 5) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check_val({tag, " busy"}, W'(busy_ok), W'(1), 0);
        check_val({tag, " latency"}, W'(lat), W'(ITER), 0);
        if (done) begin
            check_val({tag, " busy@done"}, W'(busy), W'(0), 0);
            check_results(tag);
            tick();
            check_val({tag, " done pulse"}, W'(done), W'(0), 0);
        end else begin
            void'(exp_mag_q.pop_front());
            void'(exp_ang_q.pop_front());
            void'(tol_mag_q.pop_front());
            void'(tol_ang_q.pop_front());
        end
    endtask

    logic [W-1:0] va_x, va_y, vb_x, vb_y, rx, ry;
    real          rxr, ryr;
    logic         saw_done;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_val("reset busy", W'(busy), W'(0), 0);
        check_val("reset done", W'(done), W'(0), 0);
        check_val("reset mag", magnitude, '0, 0);
        check_val("reset ang", angle, '0, 0);

        // Directed cases with fixed expected values
        push_exp(32'h0D2C_90A4, 32'h0000_0000, TOL_M, TOL_A);
        convert(32'h0800_0000, 32'h0000_0000, "x1y0");
        push_exp(32'h12A1_86F4, 32'h0648_7ED5, TOL_M, TOL_A);
        convert(32'h0800_0000, 32'h0800_0000, "q1");
        push_exp(32'h12A1_86F4, 32'hED26_8381, TOL_M, TOL_A);
        convert(32'hF800_0000, 32'hF800_0000, "q3");
        push_exp(32'h12A1_86F4, 32'h12D9_7C7F, TOL_M, TOL_A);
        convert(32'hF800_0000, 32'h0800_0000, "q2");
        push_exp(32'h0D2C_90A4, 32'h1921_FB54, TOL_M, TOL_A);
        convert(32'hF800_0000, 32'h0000_0000, "neg x axis");
        push_exp('0, '0, 0, 0);
        convert(32'h0000_0000, 32'h0000_0000, "origin");

        // Reset during a conversion: no done, outputs cleared asynchronously
        x_in  = 32'h0400_0000;
        y_in  = 32'h0C00_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check_val("abort busy", W'(busy), W'(0), 0);
        check_val("abort done", W'(done), W'(0), 0);
        check_val("abort mag", magnitude, '0, 0);
        check_val("abort ang", angle, '0, 0);
        repeat (2) tick();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < ITER + 5; c++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check_val("abort no done", W'(saw_done), W'(0), 0);
        check_val("abort mag hold", magnitude, '0, 0);

        // Start held high, operands alternating every cycle
        va_x = 32'h0400_0000; va_y = 32'hF600_0000;
        vb_x = 32'hF000_0000; vb_y = 32'h0600_0000;
        start = 1'b1;
        for (int c = 0; c < 3 * (ITER + 1); c++) begin
            x_in = (c % 2 == 0) ? va_x : vb_x;
            y_in = (c % 2 == 0) ? va_y : vb_y;
            tick();
            if (c % (ITER + 1) == 0) push_model(x_in, y_in);
            check_val($sformatf("stream done c%0d", c), W'(done),
                      W'(c % (ITER + 1) == ITER), 0);
            if (done) check_results($sformatf("stream c%0d", c));
        end
        start = 1'b0;
        tick();
        exp_mag_q.delete();
        exp_ang_q.delete();
        tol_mag_q.delete();
        tol_ang_q.delete();

        // Random sweep; tiny vectors are excluded because angle resolution
        // degrades as the vector length approaches the LSB
        for (int n = 0; n < 1000; n++) begin
            do begin
                rx  = W'(int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000);
                ry  = W'(int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000);
                rxr = from_q(rx);
                ryr = from_q(ry);
            end while (rxr * rxr + ryr * ryr < 0.25);
            push_model(rx, ry);
            convert(rx, ry, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
